// File: rtl/match_ctrl_if.sv
// Player/game-core side signals of the Bulls and Cows match sequencer.
// The slave modport is the sequencer's view and the master modport is the driver's view.
interface match_ctrl_if;
   logic       enter_pulse;
   logic       p1_win;
   logic       p2_win;
   logic       game_rst;
   logic       game_en;
   logic       setter;
   logic [3:0] round;
   logic [2:0] p1_score;
   logic [2:0] p2_score;
   logic       match_over;
   logic [1:0] match_winner;
   logic [1:0] state_dbg;

   modport slave (
      input  enter_pulse, p1_win, p2_win,
      output game_rst, game_en, setter, round, p1_score, p2_score,
             match_over, match_winner, state_dbg
   );

   modport master (
      output enter_pulse, p1_win, p2_win,
      input  game_rst, game_en, setter, round, p1_score, p2_score,
             match_over, match_winner, state_dbg
   );
endinterface

// File: rtl/match_ctrl.sv
// Match-level sequencer: starts matches, parks the game core in reset between rounds,
// alternates the secret setter and counts round wins up to WIN_TARGET.
module match_ctrl #(
   parameter int WIN_TARGET   = 3,
   parameter int INTER_CYCLES = 200_000_000,
   parameter int TMR_W        = 28
) (
   input  logic          clock,
   input  logic          reset,
   match_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      PLAY  = 2'b01,
      INTER = 2'b10,
      DONE  = 2'b11
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic             r_setter;
   logic [3:0]       r_round;
   logic [2:0]       r_p1Score;
   logic [2:0]       r_p2Score;
   logic [1:0]       r_winner;
   logic [TMR_W-1:0] r_timer;

   logic w_p1Only;
   logic w_p2Only;
   logic w_draw;
   logic w_p1Hit;
   logic w_p2Hit;
   logic w_interEnd;

   assign w_p1Only   = bus.p1_win & ~bus.p2_win;
   assign w_p2Only   = bus.p2_win & ~bus.p1_win;
   assign w_draw     = bus.p1_win & bus.p2_win;
   assign w_p1Hit    = (r_p1Score + 3'd1) == 3'(WIN_TARGET);
   assign w_p2Hit    = (r_p2Score + 3'd1) == 3'(WIN_TARGET);
   assign w_interEnd = (r_timer == '0) | bus.enter_pulse;

   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         IDLE:  if (bus.enter_pulse) w_nextState = PLAY;
         PLAY: begin
            if ((w_p1Only && w_p1Hit) || (w_p2Only && w_p2Hit)) w_nextState = DONE;
            else if (bus.p1_win || bus.p2_win)                   w_nextState = INTER;
         end
         INTER: if (w_interEnd) w_nextState = PLAY;
         DONE:  if (bus.enter_pulse) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Datapath follows the same transitions as the state register; a simultaneous
   // timer expiry and skip press is just one INTER->PLAY transition.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_setter  <= 1'b0;
         r_round   <= 4'd0;
         r_p1Score <= 3'd0;
         r_p2Score <= 3'd0;
         r_winner  <= 2'b00;
         r_timer   <= '0;
      end else begin
         unique case (r_state)
            IDLE: if (bus.enter_pulse) r_round <= 4'd1;
            PLAY: begin
               if (w_p1Only) begin
                  r_p1Score <= r_p1Score + 3'd1;
                  if (w_p1Hit) r_winner <= 2'b01;
                  else         r_timer  <= TMR_W'(INTER_CYCLES - 1);
               end else if (w_p2Only) begin
                  r_p2Score <= r_p2Score + 3'd1;
                  if (w_p2Hit) r_winner <= 2'b10;
                  else         r_timer  <= TMR_W'(INTER_CYCLES - 1);
               end else if (w_draw) begin
                  r_timer <= TMR_W'(INTER_CYCLES - 1);
               end
            end
            INTER: begin
               if (w_interEnd) begin
                  r_setter <= ~r_setter;
                  r_round  <= (r_round == 4'd15) ? 4'd15 : r_round + 4'd1;
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
            end
            DONE: begin
               if (bus.enter_pulse) begin
                  r_setter  <= 1'b0;
                  r_round   <= 4'd0;
                  r_p1Score <= 3'd0;
                  r_p2Score <= 3'd0;
                  r_winner  <= 2'b00;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.game_rst     = (r_state != PLAY);
      bus.game_en      = (r_state == PLAY);
      bus.match_over   = (r_state == DONE);
      bus.state_dbg    = r_state;
      bus.setter       = r_setter;
      bus.round        = r_round;
      bus.p1_score     = r_p1Score;
      bus.p2_score     = r_p2Score;
      bus.match_winner = r_winner;
   end

endmodule

// File: doc/match_ctrl.md
# match_ctrl

Match-level sequencer for the two-player Bulls and Cows game on the Nexys A7. It sits between the game core, the scoring LEDs and the player inputs. It starts a match, holds the game core in reset between rounds, and alternates which player sets the secret. It counts round wins until one player reaches the target score, then freezes the match until a player acknowledges the result.

## Interface
Parameters:
- WIN_TARGET, default 3: round wins needed to take the match; legal range 1..7.
- INTER_CYCLES, default 200_000_000: intermission length in clock cycles (2 s at 100 MHz); must be ≥ 1.
- TMR_W, default 28: width of the intermission counter; must hold INTER_CYCLES.

Ports:
- clock  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- enter_pulse  in  1  single-cycle, already debounced press of the enter button.
- p1_win  in  1  single-cycle pulse from the game core: P1 won the round.
- p2_win  in  1  single-cycle pulse from the game core: P2 won the round.
- game_rst  out  1  synchronous reset to the game core; high whenever not in PLAY.
- game_en  out  1  game core may accept guesses/secret; high only in PLAY.
- setter  out  1  0 = P1 sets the secret this round, 1 = P2.
- round  out  4  current round number, 0 in IDLE, 1..15, saturating at 15.
- p1_score  out  3  P1 round wins this match.
- p2_score  out  3  P2 round wins this match.
- match_over  out  1  high in DONE.
- match_winner  out  2  00 none, 01 P1, 10 P2; 11 never driven.
- state_dbg  out  2  encoded state: 00 IDLE, 01 PLAY, 10 INTER, 11 DONE.

## Operation
- All outputs are registered (Moore), decoded from state and datapath registers.
- Reset values: state IDLE, game_rst=1, game_en=0, setter=0, round=0, p1_score=0, p2_score=0, match_over=0, match_winner=00, timer=0.
- IDLE:
  - enter_pulse goes to PLAY and sets round to 1.
  - Win pulses are ignored.
- PLAY: game_rst=0, game_en=1.
  - Exactly one of p1_win/p2_win increments that player's score.
  - If the new score equals WIN_TARGET: go to DONE and set match_winner to the player.
  - Otherwise: go to INTER and load the timer with INTER_CYCLES-1.
  - p1_win and p2_win in the same cycle: draw. Neither score changes; go to INTER.
  - enter_pulse is ignored in PLAY; it belongs to the game core.
- INTER: game_rst=1, game_en=0.
  - The timer decrements each cycle.
  - On timer==0, or on enter_pulse (early skip): go to PLAY, toggle setter, and increment round (saturating at 15).
  - Timer expiry and enter_pulse in the same cycle count as a single transition.
  - Win pulses are ignored.
- DONE: game_rst=1, game_en=0, match_over=1.
  - Scores and match_winner hold.
  - enter_pulse goes to IDLE, clearing scores, round, setter and match_winner.
  - Win pulses are ignored.
- Scores never exceed WIN_TARGET.
- reset asserted in any state, including mid-intermission, forces the reset values on the next edge, overriding all other inputs.

## Timing
- Win pulse in cycle N: the score, state and game_rst updates are visible after edge N+1. This is 1-cycle latency.
- enter_pulse in cycle N: the state change is visible after edge N+1.
- game_rst is low for exactly the cycles in PLAY. It is high from the first cycle after the winning pulse, so the game core resets and clears its own win outputs before the next round.
- Intermission lasts exactly INTER_CYCLES cycles in INTER when not skipped. With INTER_CYCLES=1, INTER lasts 1 cycle.
- No combinational path from any input to any output.

## Test plan
- Reset then enter_pulse → after 1 edge: state_dbg=01, round=1, game_rst=0, game_en=1, setter=0.
- INTER_CYCLES=4, p1_win pulse in PLAY → p1_score=1, state INTER for exactly 4 cycles with game_rst=1, then PLAY with round=2 and setter=1.
- p1_win and p2_win in the same cycle → scores unchanged, INTER entered, next PLAY has setter toggled and round incremented.
- WIN_TARGET=3, P2 wins three rounds → state DONE, match_over=1, match_winner=10, p2_score=3. Later win pulses leave all outputs unchanged. enter_pulse returns to IDLE with all values cleared.
- enter_pulse in the 2nd cycle of INTER (INTER_CYCLES=100) → PLAY after 1 edge. reset asserted mid-INTER → all reset values on the next edge.
- 16 drawn rounds → round saturates at 15 and setter keeps alternating.
